// File: rtl/symbol_deserializer.sv
// Symbol deserializer: packs a framed serial bitstream into SYM_W-bit symbols
// and buffers them in a small FIFO presented with a valid/ready handshake.
module symbol_deserializer #(
   parameter int unsigned SYM_W      = 3,
   parameter int unsigned FIFO_DEPTH = 4,
   parameter bit          MSB_FIRST  = 1'b1
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          serial_in,
   input  logic                          serial_valid,
   input  logic                          frame_start,
   input  logic                          out_ready,
   output logic [SYM_W-1:0]              data,
   output logic                          data_valid,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
   output logic                          misalign,
   output logic                          overflow
);

   localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
   localparam int unsigned LVL_W = PTR_W + 1;
   localparam int unsigned CNT_W = $clog2(SYM_W + 1);

   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(SYM_W);
   localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);

   typedef enum logic {
      StUnsync,
      StActive
   } state_e;

   // Framing state
   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [SYM_W-1:0]   shift_q, shift_d;
   logic               misalign_q, misalign_d;
   logic               shifted;
   logic               push;
   logic [SYM_W-1:0]   push_sym;

   // FIFO state
   logic [SYM_W-1:0]   mem [FIFO_DEPTH];
   logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
   logic [LVL_W-1:0]   level_q, level_d;
   logic [SYM_W-1:0]   hold_q;
   logic               overflow_q;
   logic               full, empty, pop, wr_en;

   // Inserts one serial bit into a partially assembled symbol. After SYM_W
   // insertions the first bit sits at the MSB (MSB_FIRST) or at bit 0.
   function automatic logic [SYM_W-1:0] shift_in(input logic [SYM_W-1:0] base,
                                                  input logic             b);
      logic [SYM_W:0] tmp;
      if (MSB_FIRST) begin
         tmp = {base, b};
         return tmp[SYM_W-1:0];
      end else begin
         tmp = {b, base};
         return tmp[SYM_W:1];
      end
   endfunction

   // Framing FSM: next state, bit counter, shift register and symbol push
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      shift_d    = shift_q;
      misalign_d = 1'b0;
      shifted    = 1'b0;
      push       = 1'b0;
      push_sym   = shift_q;
      if (serial_valid) begin
         unique case (state_q)
            StUnsync: begin
               if (frame_start) begin
                  state_d = StActive;
                  shift_d = shift_in('0, serial_in);
                  cnt_d   = CNT_W'(1);
                  shifted = 1'b1;
               end
            end
            StActive: begin
               shifted = 1'b1;
               if (frame_start) begin
                  // Any partial bits are thrown away; this bit restarts the symbol
                  misalign_d = (cnt_q != '0);
                  shift_d    = shift_in('0, serial_in);
                  cnt_d      = CNT_W'(1);
               end else begin
                  shift_d = shift_in(shift_q, serial_in);
                  cnt_d   = cnt_q + CNT_W'(1);
               end
            end
            default: ;
         endcase
      end
      if (shifted && (cnt_d == CNT_FULL)) begin
         push     = 1'b1;
         push_sym = shift_d;
         cnt_d    = '0;
         shift_d  = '0;
      end
   end

   // Framing state register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= StUnsync;
         cnt_q      <= '0;
         shift_q    <= '0;
         misalign_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         shift_q    <= shift_d;
         misalign_q <= misalign_d;
      end
   end

   assign full  = (level_q == LVL_FULL);
   assign empty = (level_q == '0);
   assign pop   = !empty && out_ready;
   // A full FIFO still accepts a push when the head leaves in the same cycle
   assign wr_en = push && (!full || pop);

   // FIFO occupancy counter next state
   always_comb begin
      level_d = level_q;
      if (wr_en && !pop) begin
         level_d = level_q + LVL_W'(1);
      end else if (pop && !wr_en) begin
         level_d = level_q - LVL_W'(1);
      end
   end

   // FIFO storage; contents are only observed while the entry is valid
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_ptr_q] <= push_sym;
      end
   end

   // FIFO pointers, level, sticky overflow and last-popped hold value
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         level_q    <= '0;
         hold_q     <= '0;
         overflow_q <= 1'b0;
      end else begin
         level_q <= level_d;
         if (wr_en) begin
            wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            hold_q   <= mem[rd_ptr_q];
         end
         if (push && !wr_en) begin
            overflow_q <= 1'b1;
         end
      end
   end

   assign data       = empty ? hold_q : mem[rd_ptr_q];
   assign data_valid = !empty;
   assign fifo_level = level_q;
   assign misalign   = misalign_q;
   assign overflow   = overflow_q;

endmodule

// File: tb/tb_symbol_deserializer.sv
// Directed self-checking bench for symbol_deserializer (SYM_W=3, depth 4, MSB first).
module tb_symbol_deserializer;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       serial_in = 1'b0;
   logic       serial_valid = 1'b0;
   logic       frame_start = 1'b0;
   logic       out_ready = 1'b0;
   logic [2:0] data;
   logic       data_valid;
   logic [2:0] fifo_level;
   logic       misalign;
   logic       overflow;

   int checks = 0;
   int errors = 0;

   symbol_deserializer #(
      .SYM_W      (3),
      .FIFO_DEPTH (4),
      .MSB_FIRST  (1'b1)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .serial_in    (serial_in),
      .serial_valid (serial_valid),
      .frame_start  (frame_start),
      .out_ready    (out_ready),
      .data         (data),
      .data_valid   (data_valid),
      .fifo_level   (fifo_level),
      .misalign     (misalign),
      .overflow     (overflow)
   );

   // 10 ns clock
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_bit(input logic b, input logic fs);
      serial_in    = b;
      serial_valid = 1'b1;
      frame_start  = fs;
      tick();
      serial_valid = 1'b0;
      frame_start  = 1'b0;
      serial_in    = 1'b0;
   endtask

   task automatic send_sym(input logic [2:0] s);
      send_bit(s[2], 1'b1);
      send_bit(s[1], 1'b0);
      send_bit(s[0], 1'b0);
   endtask

   task automatic do_reset();
      serial_in    = 1'b0;
      serial_valid = 1'b0;
      frame_start  = 1'b0;
      out_ready    = 1'b0;
      reset        = 1'b1;
      tick();
      tick();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      #2 reset = 1'b1;
      #1;
      checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", data_valid); end
      checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL rst_level got %0d exp 0", fifo_level); end
      checks++; if (data !== 3'b000) begin errors++; $display("FAIL rst_data got %b exp 000", data); end
      checks++; if (misalign !== 1'b0) begin errors++; $display("FAIL rst_misalign got %b exp 0", misalign); end
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rst_overflow got %b exp 0", overflow); end
      tick();
      reset = 1'b0;
   endtask

   task automatic test_basic();
      do_reset();
      out_ready = 1'b1;
      send_bit(1'b0, 1'b1);
      send_bit(1'b0, 1'b0);
      send_bit(1'b1, 1'b0);
      checks++; if (data_valid !== 1'b1) begin errors++; $display("FAIL t1_valid_a got %b exp 1", data_valid); end
      checks++; if (data !== 3'b001) begin errors++; $display("FAIL t1_data_a got %b exp 001", data); end
      checks++; if (fifo_level !== 3'd1) begin errors++; $display("FAIL t1_level_a got %0d exp 1", fifo_level); end
      send_bit(1'b1, 1'b1);
      checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL t1_pop_a got %b exp 0", data_valid); end
      checks++; if (misalign !== 1'b0) begin errors++; $display("FAIL t1_no_misalign got %b exp 0", misalign); end
      send_bit(1'b0, 1'b0);
      send_bit(1'b1, 1'b0);
      checks++; if (data_valid !== 1'b1) begin errors++; $display("FAIL t1_valid_b got %b exp 1", data_valid); end
      checks++; if (data !== 3'b101) begin errors++; $display("FAIL t1_data_b got %b exp 101", data); end
      tick();
      checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL t1_pop_b got %b exp 0", data_valid); end
   endtask

   task automatic test_unsync();
      do_reset();
      out_ready = 1'b1;
      send_bit(1'b1, 1'b0);
      send_bit(1'b1, 1'b0);
      send_bit(1'b0, 1'b0);
      send_bit(1'b1, 1'b0);
      send_bit(1'b0, 1'b0);
      send_bit(1'b1, 1'b0);
      checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL t2_unsync_valid got %b exp 0", data_valid); end
      checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL t2_unsync_level got %0d exp 0", fifo_level); end
      send_sym(3'b110);
      checks++; if (data_valid !== 1'b1) begin errors++; $display("FAIL t2_valid got %b exp 1", data_valid); end
      checks++; if (data !== 3'b110) begin errors++; $display("FAIL t2_data got %b exp 110", data); end
      tick();
   endtask

   task automatic test_misalign();
      do_reset();
      out_ready = 1'b1;
      send_sym(3'b001);
      checks++; if (data !== 3'b001) begin errors++; $display("FAIL t3_first got %b exp 001", data); end
      tick();
      send_bit(1'b1, 1'b0);
      send_bit(1'b0, 1'b0);
      checks++; if (misalign !== 1'b0) begin errors++; $display("FAIL t3_early_misalign got %b exp 0", misalign); end
      send_bit(1'b0, 1'b1);
      checks++; if (misalign !== 1'b1) begin errors++; $display("FAIL t3_misalign got %b exp 1", misalign); end
      checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL t3_partial_level got %0d exp 0", fifo_level); end
      send_bit(1'b0, 1'b0);
      checks++; if (misalign !== 1'b0) begin errors++; $display("FAIL t3_misalign_clr got %b exp 0", misalign); end
      send_bit(1'b0, 1'b0);
      checks++; if (data_valid !== 1'b1) begin errors++; $display("FAIL t3_valid got %b exp 1", data_valid); end
      checks++; if (data !== 3'b000) begin errors++; $display("FAIL t3_data got %b exp 000", data); end
      checks++; if (fifo_level !== 3'd1) begin errors++; $display("FAIL t3_level got %0d exp 1", fifo_level); end
      tick();
   endtask

   task automatic test_overflow();
      logic [2:0] syms [5];
      syms[0] = 3'b011; syms[1] = 3'b100; syms[2] = 3'b111; syms[3] = 3'b010; syms[4] = 3'b110;
      do_reset();
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         send_sym(syms[i]);
         checks++; if (fifo_level !== 3'(i + 1)) begin errors++; $display("FAIL t4_fill_level%0d got %0d exp %0d", i, fifo_level, i + 1); end
      end
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL t4_ovf_early got %b exp 0", overflow); end
      send_sym(syms[4]);
      checks++; if (fifo_level !== 3'd4) begin errors++; $display("FAIL t4_full_level got %0d exp 4", fifo_level); end
      checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL t4_ovf got %b exp 1", overflow); end
      checks++; if (data !== 3'b011) begin errors++; $display("FAIL t4_stable got %b exp 011", data); end
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         checks++; if (data !== syms[i]) begin errors++; $display("FAIL t4_drain_data%0d got %b exp %b", i, data, syms[i]); end
         checks++; if (fifo_level !== 3'(4 - i)) begin errors++; $display("FAIL t4_drain_level%0d got %0d exp %0d", i, fifo_level, 4 - i); end
         tick();
      end
      checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL t4_empty got %0d exp 0", fifo_level); end
      checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL t4_ovf_sticky got %b exp 1", overflow); end
   endtask

   task automatic test_full_push_pop();
      logic [2:0] exp [4];
      exp[0] = 3'b010; exp[1] = 3'b011; exp[2] = 3'b100; exp[3] = 3'b101;
      do_reset();
      out_ready = 1'b0;
      send_sym(3'b001);
      send_sym(3'b010);
      send_sym(3'b011);
      send_sym(3'b100);
      send_bit(1'b1, 1'b1);
      send_bit(1'b0, 1'b0);
      out_ready = 1'b1;
      send_bit(1'b1, 1'b0);
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL t5_ovf got %b exp 0", overflow); end
      for (int i = 0; i < 4; i++) begin
         checks++; if (data !== exp[i]) begin errors++; $display("FAIL t5_data%0d got %b exp %b", i, data, exp[i]); end
         checks++; if (fifo_level !== 3'(4 - i)) begin errors++; $display("FAIL t5_level%0d got %0d exp %0d", i, fifo_level, 4 - i); end
         tick();
      end
      checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL t5_empty got %b exp 0", data_valid); end
   endtask

   task automatic test_async_reset();
      do_reset();
      out_ready = 1'b0;
      for (int i = 0; i < 5; i++) send_sym(3'(i + 1));
      out_ready = 1'b1;
      tick();
      tick();
      out_ready = 1'b0;
      send_bit(1'b1, 1'b1);
      checks++; if (fifo_level !== 3'd2) begin errors++; $display("FAIL t6_pre_level got %0d exp 2", fifo_level); end
      checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL t6_pre_ovf got %b exp 1", overflow); end
      #2 reset = 1'b1;
      #1;
      checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL t6_valid got %b exp 0", data_valid); end
      checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL t6_level got %0d exp 0", fifo_level); end
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL t6_ovf got %b exp 0", overflow); end
      #3 reset = 1'b0;
      tick();
      send_bit(1'b1, 1'b0);
      send_bit(1'b1, 1'b0);
      send_bit(1'b1, 1'b0);
      checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL t6_unsync_level got %0d exp 0", fifo_level); end
      send_sym(3'b010);
      checks++; if (data !== 3'b010) begin errors++; $display("FAIL t6_data got %b exp 010", data); end
      checks++; if (fifo_level !== 3'd1) begin errors++; $display("FAIL t6_post_level got %0d exp 1", fifo_level); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_unsync();
      test_misalign();
      test_overflow();
      test_full_push_pop();
      test_async_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
